psum_row_accum: RTL

- Downstream consumer of the 1-D row-convolution PE.
- Captures each DO_W-wide partial-sum row the PE emits on its done pulse.
- Vertically accumulates NROWS consecutive rows (one per filter row) into a full 2-D convolution output row.
- Saturates and optionally ReLUs the result, then presents it to the next stage (global buffer writer) over a valid/ready handshake while back-pressuring the PE launcher.

---
 rtl/psum_row_accum.sv | 105 ++++++++++
 1 files changed

// File: rtl/psum_row_accum.sv
// Vertical accumulator for PE partial-sum rows: sums NROWS rows lane by lane, saturates,
// optionally applies ReLU, and hands the finished row downstream over valid/ready.
module psum_row_accum #(
   parameter int INWIDTH = 16,
   parameter int DO_W    = 5,
   parameter int NROWS   = 3,
   parameter int ACCW    = 20,
   localparam int CW     = (NROWS > 1) ? $clog2(NROWS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pe_done,
   input  logic [DO_W*INWIDTH-1:0] pe_psum,
   input  logic                    flush,
   input  logic                    relu_en,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DO_W*INWIDTH-1:0] out_data,
   output logic [CW-1:0]           row_cnt,
   output logic [15:0]             rows_emitted,
   output logic                    ovf
);

   typedef enum logic {ACC, OUT} state_t;

   localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-INWIDTH+1){1'b0}}, {(INWIDTH-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-INWIDTH+1){1'b1}}, {(INWIDTH-1){1'b0}}};
   localparam logic signed [ACCW-1:0] AZERO = '0;

   state_t                  state, state_nxt;
   logic signed [ACCW-1:0]  acc [DO_W];
   logic signed [ACCW-1:0]  sum_p0 [DO_W];
   logic [DO_W*INWIDTH-1:0] fin_p0;
   logic [CW-1:0]           eff_cnt;
   logic                    last_row;

   function automatic logic signed [INWIDTH-1:0] sat_relu(input logic signed [ACCW-1:0] v,
                                                          input logic relu);
      logic signed [INWIDTH-1:0] r;
      if (v > SMAX)      r = SMAX[INWIDTH-1:0];
      else if (v < SMIN) r = SMIN[INWIDTH-1:0];
      else               r = v[INWIDTH-1:0];
      if (relu && r[INWIDTH-1]) r = '0;
      return r;
   endfunction

   assign in_ready  = (state == ACC);
   assign out_valid = (state == OUT);

   // A flush coinciding with pe_done makes the incoming row row 0 of a fresh group.
   always_comb begin
      eff_cnt  = flush ? '0 : row_cnt;
      last_row = (eff_cnt == CW'(NROWS-1));
      fin_p0   = '0;
      for (int i = 0; i < DO_W; i++) begin
         sum_p0[i] = ((eff_cnt == '0) ? AZERO : acc[i])
                     + ACCW'($signed(pe_psum[i*INWIDTH +: INWIDTH]));
         fin_p0[i*INWIDTH +: INWIDTH] = sat_relu(sum_p0[i], relu_en);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (pe_done && last_row) state_nxt = OUT;
         OUT:     if (out_ready)           state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ACC;
      else     state <= state_nxt;
   end

   // Stage p0 -> registered accumulator / output row
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DO_W; i++) acc[i] <= '0;
         out_data     <= '0;
         row_cnt      <= '0;
         rows_emitted <= '0;
         ovf          <= 1'b0;
      end else begin
         if (state == ACC) begin
            if (pe_done) begin
               for (int i = 0; i < DO_W; i++) acc[i] <= sum_p0[i];
               if (last_row) begin
                  row_cnt  <= '0;
                  out_data <= fin_p0;
               end else begin
                  row_cnt <= eff_cnt + CW'(1);
               end
            end else if (flush) begin
               row_cnt <= '0;
            end
         end else begin
            if (pe_done)   ovf <= 1'b1;
            if (out_ready) rows_emitted <= rows_emitted + 16'd1;
         end
      end
   end

endmodule
